// File: rtl/regfile_writeback_pkg.sv
// Register file constants and the writeback entry type shared by the writeback block.
// Latency: n/a (types and constants only). Backpressure: n/a.
package regfile_writeback_pkg;

    localparam int WIDTH        = 32;
    localparam int ADRESS_WIDTH = 5;
    localparam int DEPTH        = 32;

    localparam logic [ADRESS_WIDTH-1:0] X0 = '0;

    typedef struct packed {
        logic [ADRESS_WIDTH-1:0] rd;
        logic [WIDTH-1:0]        data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register file write port and load-tracking status of the writeback block.
// Latency: n/a (wires only). Backpressure: alu_ready / mem_ready driven by the slave side.
interface regfile_writeback_if
    import regfile_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) ();

    logic                          alu_valid;
    logic                          alu_ready;
    logic [ADRESS_WIDTH-1:0]       alu_rd;
    logic [WIDTH-1:0]              alu_data;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADRESS_WIDTH-1:0]       mem_rd;
    logic [WIDTH-1:0]              mem_data;
    logic                          we0;
    logic [ADRESS_WIDTH-1:0]       wr_addr0;
    logic [WIDTH-1:0]              wr_din0;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [DEPTH-1:0]              pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, we0, wr_addr0, wr_din0, fifo_count, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, we0, wr_addr0, wr_din0, fifo_count, pending_mask
    );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_sync_fifo: synchronous FIFO of writeback entries, exposes per-slot rd/valid for hazard masks.
// Latency: push visible at head the cycle after. Backpressure: push ignored when full, pop ignored when empty.
module wb_sync_fifo
    import regfile_writeback_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      push_i,
    input  wb_entry_t                                 push_dat_i,
    input  logic                                      pop_i,
    output wb_entry_t                                 head_dat_o,
    output logic [CNT_W-1:0]                          count_o,
    output logic                                      empty_o,
    output logic [FIFO_DEPTH-1:0]                     ent_vld_o,
    output logic [FIFO_DEPTH-1:0][ADRESS_WIDTH-1:0]   ent_rd_o
);

    wb_entry_t               entries_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pop is applied before push so a slot freed and refilled in one cycle stays valid.
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = PTR_W'(rd_ptr_q + 1'b1);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = PTR_W'(wr_ptr_q + 1'b1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_rd_o[i] = entries_q[i].rd;
        end
    end

    assign head_dat_o = entries_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign ent_vld_o  = valid_q;

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and queued load results onto the register file write port; optional WB_STARVE_GUARD_EN.
// Latency: ALU 1 cycle, load >= 2 cycles. Backpressure: mem_ready = FIFO not full; ALU always wins unless starve guard fires.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                               head_dat, sel_dat, push_dat;
    logic [CNT_W-1:0]                        count;
    logic                                    empty;
    logic [FIFO_DEPTH-1:0]                   ent_vld;
    logic [FIFO_DEPTH-1:0][ADRESS_WIDTH-1:0] ent_rd;
    logic                                    alu_ready, alu_fire, mem_ready, push, pop, sel_vld;
    logic [DEPTH-1:0]                        pending_mask;

    logic                                    we0_q, we0_d;
    logic [ADRESS_WIDTH-1:0]                 wr_addr0_q, wr_addr0_d;
    logic [WIDTH-1:0]                        wr_din0_q, wr_din0_d;

    assign mem_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push      = bus.mem_valid && mem_ready;
    assign alu_fire  = bus.alu_valid && alu_ready;
    assign pop       = !alu_fire && !empty;
    assign push_dat  = '{rd: bus.mem_rd, data: bus.mem_data};

    wb_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count),
        .empty_o    (empty),
        .ent_vld_o  (ent_vld),
        .ent_rd_o   (ent_rd)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    // Holding off the ALU for one cycle lets the pop path win arbitration.
    assign alu_ready = (starve_q != SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (alu_fire) begin
            starve_d = SW'(starve_q + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(STARVE_LIMIT);
    assign alu_ready  = 1'b1;
`endif

    assign sel_vld = alu_fire || pop;
    assign sel_dat = alu_fire ? '{rd: bus.alu_rd, data: bus.alu_data} : head_dat;

    always_comb begin
        we0_d      = 1'b0;
        wr_addr0_d = wr_addr0_q;
        wr_din0_d  = wr_din0_q;
        if (sel_vld) begin
            we0_d      = (sel_dat.rd != X0);
            wr_addr0_d = sel_dat.rd;
            wr_din0_d  = sel_dat.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we0_q      <= 1'b0;
            wr_addr0_q <= '0;
            wr_din0_q  <= '0;
        end else begin
            we0_q      <= we0_d;
            wr_addr0_q <= wr_addr0_d;
            wr_din0_q  <= wr_din0_d;
        end
    end

    // Built from registered slot state, so a popped entry's bit drops the cycle after its pop.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i]) begin
                pending_mask[ent_rd[i]] = 1'b1;
            end
        end
        pending_mask[X0] = 1'b0;
    end

    assign bus.alu_ready    = alu_ready;
    assign bus.mem_ready    = mem_ready;
    assign bus.we0          = we0_q;
    assign bus.wr_addr0     = wr_addr0_q;
    assign bus.wr_din0      = wr_din0_q;
    assign bus.fifo_count   = count;
    assign bus.pending_mask = pending_mask;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed table-driven bench for regfile_writeback plus hand-written reset and starvation sequences.
// Latency: n/a. Backpressure: producers hold data while ready is low.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    regfile_writeback_if #(.FIFO_DEPTH(4)) bus ();

    regfile_writeback #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic [31:0] mask;
        logic        mrdy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                                logic mv, logic [4:0] mr, logic [31:0] md,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [2:0] cnt, logic [31:0] mask, logic mrdy);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
        v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt; v.mask = mask; v.mrdy = mrdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mr;
        bus.mem_data  = md;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] alu_d;
        logic        exp_rdy;
        logic        exp_pop;

        // Outputs after each edge; ALU is kept busy on rd 9 so the loads can pile up to full.
        vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,      1, 5,  32'hDEADBEEF, 0, 32'h0,    1);
        vecs[1]  = mk(0, 0,  0,            0, 0,  0,      0, 5,  32'hDEADBEEF, 0, 32'h0,    1);
        vecs[2]  = mk(1, 9,  32'hA0,       1, 1,  32'h10, 1, 9,  32'hA0,       1, 32'h2,    1);
        vecs[3]  = mk(1, 9,  32'hA1,       1, 2,  32'h20, 1, 9,  32'hA1,       2, 32'h6,    1);
        vecs[4]  = mk(1, 9,  32'hA2,       1, 3,  32'h30, 1, 9,  32'hA2,       3, 32'hE,    1);
        vecs[5]  = mk(1, 9,  32'hA3,       1, 4,  32'h40, 1, 9,  32'hA3,       4, 32'h1E,   0);
        vecs[6]  = mk(0, 0,  0,            1, 8,  32'h80, 1, 1,  32'h10,       3, 32'h1C,   1);
        vecs[7]  = mk(0, 0,  0,            0, 0,  0,      1, 2,  32'h20,       2, 32'h18,   1);
        vecs[8]  = mk(0, 0,  0,            0, 0,  0,      1, 3,  32'h30,       1, 32'h10,   1);
        vecs[9]  = mk(0, 0,  0,            0, 0,  0,      1, 4,  32'h40,       0, 32'h0,    1);
        vecs[10] = mk(0, 0,  0,            0, 0,  0,      0, 4,  32'h40,       0, 32'h0,    1);
        vecs[11] = mk(1, 10, 32'hB0,       1, 7,  32'h70, 1, 10, 32'hB0,       1, 32'h80,   1);
        vecs[12] = mk(1, 11, 32'hB1,       0, 0,  0,      1, 11, 32'hB1,       1, 32'h80,   1);
        vecs[13] = mk(1, 12, 32'hB2,       0, 0,  0,      1, 12, 32'hB2,       1, 32'h80,   1);
        vecs[14] = mk(0, 0,  0,            0, 0,  0,      1, 7,  32'h70,       0, 32'h0,    1);
        vecs[15] = mk(0, 0,  0,            0, 0,  0,      0, 7,  32'h70,       0, 32'h0,    1);
        vecs[16] = mk(1, 0,  32'h1234,     1, 0,  32'h55, 0, 0,  32'h1234,     1, 32'h0,    1);
        vecs[17] = mk(0, 0,  0,            0, 0,  0,      0, 0,  32'h55,       0, 32'h0,    1);
        vecs[18] = mk(1, 13, 32'hC0,       1, 14, 32'hE0, 1, 13, 32'hC0,       1, 32'h4000, 1);
        vecs[19] = mk(1, 13, 32'hC1,       1, 15, 32'hF0, 1, 13, 32'hC1,       2, 32'hC000, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_we0",   32'(bus.we0),          32'h0);
        chk("reset_addr",  32'(bus.wr_addr0),     32'h0);
        chk("reset_din",   bus.wr_din0,           32'h0);
        chk("reset_count", 32'(bus.fifo_count),   32'h0);
        chk("reset_mask",  bus.pending_mask,      32'h0);
        chk("reset_mrdy",  32'(bus.mem_ready),    32'h1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we0", i),   32'(bus.we0),        32'(vecs[i].we));
            chk($sformatf("v%0d_addr", i),  32'(bus.wr_addr0),   32'(vecs[i].wa));
            chk($sformatf("v%0d_din", i),   bus.wr_din0,         vecs[i].wd);
            chk($sformatf("v%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_mask", i),  bus.pending_mask,    vecs[i].mask);
            chk($sformatf("v%0d_mrdy", i),  32'(bus.mem_ready),  32'(vecs[i].mrdy));
            chk($sformatf("v%0d_ardy", i),  32'(bus.alu_ready),  32'h1);
        end

        // Reset with rd 14/15 still queued: both must vanish without ever being written.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_count", 32'(bus.fifo_count), 32'h0);
        chk("rst_mid_mask",  bus.pending_mask,    32'h0);
        chk("rst_mid_we0",   32'(bus.we0),        32'h0);
        chk("rst_mid_addr",  32'(bus.wr_addr0),   32'h0);
        chk("rst_mid_din",   bus.wr_din0,         32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_after%0d_we0", k),   32'(bus.we0),        32'h0);
            chk($sformatf("rst_after%0d_count", k), 32'(bus.fifo_count), 32'h0);
        end

        // One load queued behind a continuous ALU stream.
        @(negedge clk);
        drive(1, 21, 32'h300, 1, 20, 32'h200);
        @(posedge clk);
        #1;
        chk("starve_push_addr",  32'(bus.wr_addr0),   32'd21);
        chk("starve_push_count", 32'(bus.fifo_count), 32'h1);
        chk("starve_push_mask",  bus.pending_mask,    32'h0010_0000);

        alu_d = 32'h301;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            drive(1, 21, alu_d, 0, 0, 0);
`ifdef WB_STARVE_GUARD_EN
            exp_pop = (k == 9);
            exp_rdy = !exp_pop;
`else
            exp_pop = 1'b0;
            exp_rdy = 1'b1;
`endif
            #1;
            chk($sformatf("starve_k%0d_ardy", k), 32'(bus.alu_ready), 32'(exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("starve_k%0d_we0", k), 32'(bus.we0), 32'h1);
            if (exp_pop) begin
                chk($sformatf("starve_k%0d_addr", k), 32'(bus.wr_addr0), 32'd20);
                chk($sformatf("starve_k%0d_din", k),  bus.wr_din0,       32'h200);
            end else begin
                chk($sformatf("starve_k%0d_addr", k), 32'(bus.wr_addr0), 32'd21);
                chk($sformatf("starve_k%0d_din", k),  bus.wr_din0,       alu_d);
            end
`ifdef WB_STARVE_GUARD_EN
            chk($sformatf("starve_k%0d_count", k), 32'(bus.fifo_count), (k >= 9) ? 32'h0 : 32'h1);
`else
            chk($sformatf("starve_k%0d_count", k), 32'(bus.fifo_count), 32'h1);
`endif
            if (exp_rdy) begin
                alu_d = alu_d + 32'h1;
            end
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
